// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, stage state and requester ids
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    typedef enum logic [1:0] {
        REQ_WB   = 2'd0,
        REQ_LINK = 2'd1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
// Ports:
//   req      in  N_REQ  request bits
//   ptr      in  ID_W   highest-priority requester this cycle
//   grant    out N_REQ  one-hot winner (all zero when no request)
//   grant_id out ID_W   encoded winner (zero when no request)
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    // One extra bit so ptr + offset never wraps before the modulo step.
    logic [ID_W:0]   pos;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        pos      = '0;
        idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N_REQ)) begin
                pos = pos - (ID_W+1)'(N_REQ);
            end
            idx = pos[ID_W-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the single register-file write port
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake
//   req_addr/req_data      per-requester destination and data, slice i = requester i
//   wr_allow               control FSM permits a commit this cycle
//   wr_en/wr_addr/wr_data  register-file write port driven from the held entry
//   wr_sel                 one-hot write enable, never set for register 0
//   grant_id               owner of the held entry
//   query_addr/busy/data   hazard and bypass lookup against the held entry
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    localparam int ID_W  = $clog2(N_REQ),
    localparam int SEL_W = 2**ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    wr_allow,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [SEL_W-1:0]        wr_sel,
    output logic [ID_W-1:0]         grant_id,
    input  logic [ADDR_W-1:0]       query_addr,
    output logic                    query_busy,
    output logic [DATA_W-1:0]       query_data
);

    stage_state_e      state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [N_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]   arb_id;
    logic              stage_full;
    logic              accept_open;
    logic              any_accept;
    logic              commit;
    logic              nonzero_dst;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ID_W-1:0]   ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    assign stage_full  = (state_q == ST_FULL);
    assign commit      = stage_full & wr_allow;
    // The stage can take a new entry when empty, or when the current one
    // leaves this cycle; rst_n gates it so nothing handshakes during reset.
    assign accept_open = rst_n & (~stage_full | wr_allow);
    assign req_ready   = accept_open ? arb_grant : '0;
    assign any_accept  = |req_ready;

    // Grant is one-hot, so OR-ing masked slices is a clean mux.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (arb_id == ID_W'(N_REQ-1)) ? '0 : arb_id + ID_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (any_accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (wr_allow && !any_accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            ptr_q    <= '0;
        end else if (any_accept) begin
            wr_addr  <= sel_addr;
            wr_data  <= sel_data;
            grant_id <= arb_id;
            ptr_q    <= ptr_next;
        end
    end

    assign nonzero_dst = (wr_addr != ADDR_W'(ZERO_REG));
    assign wr_en       = commit & nonzero_dst;

    always_comb begin
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
    end

    // Busy through the commit cycle itself: the register file only holds the
    // value from the next cycle on, so the bypass is still needed now.
    assign query_busy = stage_full & nonzero_dst & (wr_addr == query_addr);
    assign query_data = wr_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            wr_allow = 1'b0;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [31:0]     wr_sel;
    logic [0:0]      grant_id;
    logic [AW-1:0]   query_addr = '0;
    logic            query_busy;
    logic [DW-1:0]   query_data;

    int total = 0;
    int bad   = 0;

    regfile_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .wr_allow   (wr_allow),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_sel     (wr_sel),
        .grant_id   (grant_id),
        .query_addr (query_addr),
        .query_busy (query_busy),
        .query_data (query_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one held entry plus a rotating priority start.
    logic         m_full = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int           m_gid = 0;
    int           m_ptr = 0;
    logic [N-1:0] m_acc = '0;

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        if (!rst_n) return '0;
        if (m_full && !wr_allow) return '0;
        w = winner(req_valid, m_ptr);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [N-1:0] a;
        int w;
        if (!rst_n) begin
            m_full <= 1'b0; m_addr <= '0; m_data <= '0;
            m_gid <= 0; m_ptr <= 0; m_acc <= '0;
        end else begin
            a = exp_ready();
            m_acc <= a;
            if (a != 0) begin
                w = winner(req_valid, m_ptr);
                m_full <= 1'b1;
                m_addr <= req_addr[w*AW +: AW];
                m_data <= req_data[w*DW +: DW];
                m_gid  <= w;
                m_ptr  <= (w + 1) % N;
            end else if (m_full && wr_allow) begin
                m_full <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic        e_en;
        logic [31:0] e_sel;
        e_en  = m_full && wr_allow && (m_addr != 0);
        e_sel = e_en ? (32'h1 << m_addr) : 32'h0;
        chk("m_req_ready", {62'b0, req_ready}, {62'b0, exp_ready()});
        chk("m_wr_en", {63'b0, wr_en}, {63'b0, e_en});
        chk("m_wr_sel", {32'b0, wr_sel}, {32'b0, e_sel});
        chk("m_query_busy", {63'b0, query_busy},
            {63'b0, m_full && (m_addr == query_addr) && (m_addr != 0)});
        if (m_full) begin
            chk("m_wr_addr", {59'b0, wr_addr}, {59'b0, m_addr});
            chk("m_wr_data", {32'b0, wr_data}, {32'b0, m_data});
            chk("m_grant_id", {63'b0, grant_id}, 64'(m_gid));
            chk("m_query_data", {32'b0, query_data}, {32'b0, m_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t2_sel [4];

    initial begin
        t2_sel[0] = 32'h8; t2_sel[1] = 32'h80; t2_sel[2] = 32'h8; t2_sel[3] = 32'h80;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", {63'b0, wr_en}, 64'h0);
        chk("rst_ready", {62'b0, req_ready}, 64'h0);
        chk("rst_wr_addr", {59'b0, wr_addr}, 64'h0);
        chk("rst_grant_id", {63'b0, grant_id}, 64'h0);

        // 1: single write to r5
        tick();
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd5; req_data[0 +: DW] = 32'hDEADBEEF;
        wr_allow = 1'b1;
        @(negedge clk);
        chk("t1_ready", {62'b0, req_ready}, 64'h1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_wr_en", {63'b0, wr_en}, 64'h1);
        chk("t1_wr_addr", {59'b0, wr_addr}, 64'h5);
        chk("t1_wr_sel", {32'b0, wr_sel}, 64'h20);
        chk("t1_wr_data", {32'b0, wr_data}, 64'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("t1_idle", {63'b0, wr_en}, 64'h0);

        // 4: requester 1 writes r0, consumed silently
        tick();
        req_valid = 2'b10; req_addr[AW +: AW] = 5'd0; req_data[DW +: DW] = 32'h1234;
        query_addr = 5'd0;
        @(negedge clk);
        chk("t4_ready", {62'b0, req_ready}, 64'h2);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t4_wr_en", {63'b0, wr_en}, 64'h0);
        chk("t4_wr_sel", {32'b0, wr_sel}, 64'h0);
        chk("t4_busy", {63'b0, query_busy}, 64'h0);
        chk("t4_gid", {63'b0, grant_id}, 64'h1);
        chk("t4_data", {32'b0, wr_data}, 64'h1234);
        tick();

        // 2: continuous contention, back-to-back alternation
        req_valid = 2'b11;
        req_addr[0 +: AW] = 5'd3;  req_data[0 +: DW]  = 32'h3333;
        req_addr[AW +: AW] = 5'd7; req_data[DW +: DW] = 32'h7777;
        @(negedge clk);
        chk("t2_first", {62'b0, req_ready}, 64'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_wr_sel", {32'b0, wr_sel}, {32'b0, t2_sel[k]});
            chk("t2_gid", {63'b0, grant_id}, 64'(k % 2));
        end
        tick();
        req_valid = 2'b00;
        tick();

        // 3: hold r9 with wr_allow low, requester 1 blocked
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd9; req_data[0 +: DW] = 32'hA5A50009;
        wr_allow = 1'b0; query_addr = 5'd9;
        tick();
        req_valid = 2'b10; req_addr[AW +: AW] = 5'd7; req_data[DW +: DW] = 32'h77;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_ready", {62'b0, req_ready}, 64'h0);
            chk("t3_wr_en", {63'b0, wr_en}, 64'h0);
            chk("t3_busy", {63'b0, query_busy}, 64'h1);
            chk("t3_qdata", {32'b0, query_data}, 64'hA5A50009);
            tick();
        end
        wr_allow = 1'b1;
        @(negedge clk);
        chk("t3_commit_en", {63'b0, wr_en}, 64'h1);
        chk("t3_commit_sel", {32'b0, wr_sel}, 64'h200);
        chk("t3_commit_busy", {63'b0, query_busy}, 64'h1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t3_after_busy", {63'b0, query_busy}, 64'h0);
        chk("t3_after_sel", {32'b0, wr_sel}, 64'h80);
        tick();
        tick();

        // 5: reset while holding r12
        req_valid = 2'b01; req_addr[0 +: AW] = 5'd12; req_data[0 +: DW] = 32'hC0C0;
        wr_allow = 1'b0; query_addr = 5'd12;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t5_busy", {63'b0, query_busy}, 64'h1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        wr_allow = 1'b1;
        #1;
        chk("t5_rst_en", {63'b0, wr_en}, 64'h0);
        chk("t5_rst_sel", {32'b0, wr_sel}, 64'h0);
        chk("t5_rst_busy", {63'b0, query_busy}, 64'h0);
        chk("t5_rst_addr", {59'b0, wr_addr}, 64'h0);
        chk("t5_rst_data", {32'b0, wr_data}, 64'h0);
        tick();
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_addr[0 +: AW] = 5'd3; req_addr[AW +: AW] = 5'd7;
        @(negedge clk);
        chk("t5_prio", {62'b0, req_ready}, 64'h1);
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();

        // Random traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            wr_allow   = ($urandom_range(0, 3) != 0);
            query_addr = ($urandom_range(0, 1) != 0) ? m_addr : AW'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
